// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch stage: FSM state encoding,
// the NOP encoding presented to decode while idle, the default reset PC and
// a word-alignment helper.
// -----------------------------------------------------------------------------
package fetch_pkg;

   typedef enum logic [1:0] {
      RESET = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } fetch_state_e;

   localparam logic [31:0] INST_NOP         = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Synchronous FIFO holding {pc, inst} pairs for the fetch stage. The head
// entry is always held in an output register, so data pushed in cycle N is
// visible on rdata_o in cycle N+1 with no combinational path from push data.
//
// Ports:
//   clk, reset    clock and synchronous active-high reset
//   clear_i       empties the FIFO (wins over push/pop)
//   push_i        write push_data_i at the tail
//   push_data_i   {pc, inst}
//   pop_i         drop the head entry (caller guarantees not empty)
//   count_o       number of valid entries
//   rdata_o       registered head entry, meaningful when count_o != 0
// -----------------------------------------------------------------------------
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clear_i,
   input  logic                    push_i,
   input  logic [WIDTH-1:0]        push_data_i,
   input  logic                    pop_i,
   output logic [$clog2(DEPTH):0]  count_o,
   output logic [WIDTH-1:0]        rdata_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      rdata_d  = rdata_q;
      if (clear_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
         if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
         count_d = count_q + CW'(push_i) - CW'(pop_i);
         // The slot being written becomes the head when the FIFO is (or is
         // about to become) empty; otherwise the head comes from storage.
         if (push_i && (wr_ptr_q == rd_ptr_d))
            rdata_d = push_data_i;
         else
            rdata_d = mem_q[rd_ptr_d];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         rdata_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         rdata_q  <= rdata_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_i && !clear_i)
         mem_q[wr_ptr_q] <= push_data_i;
   end

   assign count_o = count_q;
   assign rdata_o = rdata_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit
// Owns the PC, issues word-aligned requests to instruction memory, buffers
// in-order responses in fetch_fifo and hands {inst, pc} to decode over a
// valid/ready handshake. Redirects flush buffered data and discard responses
// to requests still in flight (DRAIN state).
//
// Optional feature: define INST_FETCH_PERF_EN to add the perf_delivered and
// perf_bubble counter outputs.
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   imem_req_valid/ready/addr        fetch request channel
//   imem_rsp_valid/data              in-order response, no backpressure
//   redirect_valid/pc                redirect from execute
//   dec_valid/ready/inst_code/pc     decode handshake (NOP / 0 when idle)
//   perf_delivered, perf_bubble      decode handshakes / starved cycles
// -----------------------------------------------------------------------------
module inst_fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        dec_valid,
   input  logic        dec_ready,
   output logic [31:0] dec_inst_code,
`ifdef INST_FETCH_PERF_EN
   output logic [31:0] dec_pc,
   output logic [31:0] perf_delivered,
   output logic [31:0] perf_bubble
`else
   output logic [31:0] dec_pc
`endif
);

   localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

   fetch_state_e  state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic [CW-1:0] outst_q, outst_d;
   logic [CW-1:0] drop_q, drop_d;

   logic          req_fire;
   logic          fifo_push, fifo_pop, fifo_clear;
   logic [CW-1:0] fifo_count;
   logic [63:0]   fifo_rdata;
   logic [CW:0]   occupancy;
   logic [31:0]   rsp_pc;

   assign req_fire  = imem_req_valid && imem_req_ready;
   assign occupancy = {1'b0, outst_q} + {1'b0, fifo_count};

   // Requests issued in FETCH are consecutive words ending just below pc_q,
   // so the oldest one in flight sits outst_q words behind it.
   assign rsp_pc = pc_q - {{(30-CW){1'b0}}, outst_q, 2'b00};

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (64)
   ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .clear_i     (fifo_clear),
      .push_i      (fifo_push),
      .push_data_i ({rsp_pc, imem_rsp_data}),
      .pop_i       (fifo_pop),
      .count_o     (fifo_count),
      .rdata_o     (fifo_rdata)
   );

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RESET;
         pc_q    <= RESET_PC;
         outst_q <= '0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         outst_q <= outst_d;
         drop_q  <= drop_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      outst_d    = outst_q;
      drop_d     = drop_q;
      fifo_push  = 1'b0;
      fifo_pop   = 1'b0;
      fifo_clear = 1'b0;
      case (state_q)
         RESET: state_d = FETCH;
         default: begin
            if (redirect_valid) begin
               // Everything still in flight (including a request accepted
               // now, minus a response discarded now) becomes stale.
               fifo_clear = 1'b1;
               pc_d       = word_align(redirect_pc);
               drop_d     = outst_q + CW'(req_fire) - CW'(imem_rsp_valid);
               outst_d    = drop_d;
               state_d    = (drop_d != '0) ? DRAIN : FETCH;
            end else if (state_q == FETCH) begin
               if (req_fire) pc_d = pc_q + 32'd4;
               outst_d   = outst_q + CW'(req_fire) - CW'(imem_rsp_valid);
               fifo_push = imem_rsp_valid;
               fifo_pop  = dec_valid && dec_ready;
            end else begin
               if (imem_rsp_valid) begin
                  drop_d  = drop_q - CW'(1);
                  outst_d = outst_q - CW'(1);
               end
               if (drop_d == '0) state_d = FETCH;
            end
         end
      endcase
   end

   // Outputs; forced to reset values while reset is asserted
   always_comb begin
      imem_req_valid = 1'b0;
      imem_req_addr  = pc_q;
      dec_valid      = 1'b0;
      dec_inst_code  = INST_NOP;
      dec_pc         = '0;
      if (reset) begin
         imem_req_addr = RESET_PC;
      end else begin
         imem_req_valid = (state_q == FETCH) && (occupancy < DEPTH_C);
         if (fifo_count != '0) begin
            dec_valid     = 1'b1;
            dec_inst_code = fifo_rdata[31:0];
            dec_pc        = fifo_rdata[63:32];
         end
      end
   end

`ifdef INST_FETCH_PERF_EN
   logic [31:0] perf_delivered_q, perf_bubble_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         perf_delivered_q <= '0;
         perf_bubble_q    <= '0;
      end else begin
         if (dec_valid && dec_ready)  perf_delivered_q <= perf_delivered_q + 32'd1;
         if (!dec_valid && dec_ready) perf_bubble_q    <= perf_bubble_q + 32'd1;
      end
   end

   assign perf_delivered = perf_delivered_q;
   assign perf_bubble    = perf_bubble_q;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_unit
// Randomised bench for inst_fetch_unit. An in-order memory model with random
// latency answers requests; a scoreboard tracks which fetched words are still
// deliverable (redirects make everything in flight stale) and the expected
// request address stream.
// -----------------------------------------------------------------------------
module tb_inst_fetch_unit;
   import fetch_pkg::*;

   localparam int          DEPTH  = 2;
   localparam logic [31:0] RST_PC = 32'h0000_2000;

   logic        clk;
   logic        reset;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        dec_valid;
   logic        dec_ready;
   logic [31:0] dec_inst_code;
   logic [31:0] dec_pc;
`ifdef INST_FETCH_PERF_EN
   logic [31:0] perf_delivered;
   logic [31:0] perf_bubble;
`endif

   inst_fetch_unit #(
      .RESET_PC   (RST_PC),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .dec_valid      (dec_valid),
      .dec_ready      (dec_ready),
      .dec_inst_code  (dec_inst_code),
`ifdef INST_FETCH_PERF_EN
      .dec_pc         (dec_pc),
      .perf_delivered (perf_delivered),
      .perf_bubble    (perf_bubble)
`else
      .dec_pc         (dec_pc)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      bit          stale;
      int          due;
   } req_t;

   req_t        pend[$];      // requests accepted by memory, oldest first
   logic [31:0] exp_q[$];     // PCs still due to reach decode, in order
   logic [31:0] exp_req_pc;
   bit          expect_req_next;
   bit          s_req_valid;
   int          cyc;
   int          n_checks;
   int          n_fail;
   int          exp_deliv;
   int          exp_bubble;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Evaluate the cycle's events at the falling edge, then advance the model.
   task automatic observe_cycle();
      bit   fire, rsp, redir, pop;
      int   start_pend, start_buf;
      req_t r;
      fire       = imem_req_valid && imem_req_ready;
      rsp        = imem_rsp_valid;
      redir      = redirect_valid;
      start_pend = pend.size();
      start_buf  = exp_q.size();
      pop        = dec_ready && (start_buf != 0);
      s_req_valid = imem_req_valid;

      if (expect_req_next) begin
         chk("redir_req_valid", 32'(imem_req_valid), 32'd1);
         chk("redir_req_addr", imem_req_addr, exp_req_pc);
         expect_req_next = 1'b0;
      end
      chk("dec_valid", 32'(dec_valid), 32'(start_buf != 0));
      if (start_buf != 0) begin
         chk("dec_pc", dec_pc, exp_q[0]);
         chk("dec_inst", dec_inst_code, mem_word(exp_q[0]));
      end else begin
         chk("idle_inst", dec_inst_code, INST_NOP);
         chk("idle_pc", dec_pc, 32'd0);
      end
      if (start_pend + start_buf >= DEPTH)
         chk("req_over_cap", 32'(imem_req_valid), 32'd0);
      if (fire)
         chk("req_addr", imem_req_addr, exp_req_pc);

      if (dec_ready && start_buf != 0) exp_deliv++;
      if (dec_ready && start_buf == 0) exp_bubble++;

      if (pop && !redir) void'(exp_q.pop_front());
      if (rsp && pend.size() != 0) begin
         r = pend.pop_front();
         if (!redir && !r.stale) exp_q.push_back(r.addr);
      end
      if (fire) begin
         r.addr  = exp_req_pc;
         r.stale = redir;
         r.due   = cyc + 1 + int'($urandom_range(2));
         pend.push_back(r);
         exp_req_pc = exp_req_pc + 32'd4;
      end
      if (redir) begin
         exp_q.delete();
         foreach (pend[i]) pend[i].stale = 1'b1;
         exp_req_pc = redirect_pc & ~32'h3;
         if (start_pend + int'(fire) - int'(rsp) == 0) expect_req_next = 1'b1;
      end
   endtask

   task automatic step(input bit mem_rdy, input int rsp_pct, input bit drdy,
                       input bit redir, input logic [31:0] rpc);
      @(posedge clk);
      #1;
      imem_req_ready = mem_rdy;
      dec_ready      = drdy;
      redirect_valid = redir;
      redirect_pc    = rpc;
      if (pend.size() != 0 && pend[0].due <= cyc &&
          int'($urandom_range(99)) < rsp_pct) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_word(pend[0].addr);
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = $urandom;
      end
      @(negedge clk);
      observe_cycle();
      cyc++;
   endtask

   task automatic check_idle_outputs(input string pfx);
      chk({pfx, "_req_valid"}, 32'(imem_req_valid), 32'd0);
      chk({pfx, "_req_addr"}, imem_req_addr, RST_PC);
      chk({pfx, "_dec_valid"}, 32'(dec_valid), 32'd0);
      chk({pfx, "_dec_inst"}, dec_inst_code, INST_NOP);
      chk({pfx, "_dec_pc"}, dec_pc, 32'd0);
   endtask

   initial begin
      bit          mr, dr, rd;
      logic [31:0] rp;
      n_checks = 0;
      n_fail = 0;
      cyc = 0;
      exp_deliv = 0;
      exp_bubble = 0;
      expect_req_next = 1'b0;
      reset = 1'b1;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data = '0;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      dec_ready = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle_outputs("rst");
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_idle_outputs("post_rst");

      exp_req_pc = RST_PC;
      step(1'b1, 100, 1'b1, 1'b0, $urandom);
      chk("first_fetch_valid", 32'(s_req_valid), 32'd1);

      // Streaming with always-ready memory and decode
      repeat (12) step(1'b1, 100, 1'b1, 1'b0, $urandom);
      // Decode stalled for 10 cycles, then released
      repeat (10) step(1'b1, 100, 1'b0, 1'b0, $urandom);
      repeat (10) step(1'b1, 100, 1'b1, 1'b0, $urandom);
      // Build up outstanding requests, redirect to an unaligned target
      repeat (4) step(1'b1, 0, 1'b1, 1'b0, $urandom);
      step(1'b1, 0, 1'b1, 1'b1, 32'h0000_0103);
      repeat (10) step(1'b1, 100, 1'b1, 1'b0, $urandom);
      // Redirect while streaming (response/pop likely in the same cycle)
      repeat (6) step(1'b1, 100, 1'b1, 1'b0, $urandom);
      step(1'b1, 100, 1'b1, 1'b1, 32'h0000_0200);
      repeat (6) step(1'b1, 100, 1'b1, 1'b0, $urandom);
      // PC wrap-around at the top of the address space
      step(1'b1, 100, 1'b1, 1'b1, 32'hFFFF_FFF6);
      repeat (12) step(1'b1, 100, 1'b1, 1'b0, $urandom);

      // Randomised traffic
      for (int i = 0; i < 3000; i++) begin
         mr = ($urandom_range(3) != 0);
         dr = ($urandom_range(9) < 7);
         rd = ($urandom_range(24) == 0);
         rp = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
         step(mr, 70, dr, rd, rp);
      end

      // Stop issuing and let everything in flight reach decode
      repeat (20) step(1'b0, 100, 1'b1, 1'b0, $urandom);
      chk("final_dec_valid", 32'(dec_valid), 32'd0);

`ifdef INST_FETCH_PERF_EN
      chk("perf_delivered", perf_delivered, 32'(exp_deliv));
      chk("perf_bubble", perf_bubble, 32'(exp_bubble));
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
